segre_hazard_ctrl: RTL and testbench
====================================

# segre_hazard_ctrl

Issue controller for the ID stage of the Segre core. Keeps a shadow scoreboard of every register-writing instruction in flight in the main pipe (EX, MEM, WB) and the M-extension pipe (M1–M5). Each cycle it selects the ID operand bypass sources, and decides whether ID must hold its instruction or send a bubble downstream. Sits beside the ID stage; drives the ID stage's `block_id_i`, `inject_nops_i`, `mux_sel_a_id_i` and `mux_sel_b_id_i`.

## Interface
Parameters:
- `NUM_M_STAGES`, default 5: depth of the M pipe; bypass exists only from the last stage.
- `CNT_W`, default 32: width of the stall counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_id_i`  in  1  ID holds a valid instruction (main or M-ext).
- `is_m_ext_i`  in  1  ID instruction goes to the M pipe.
- `src_a_id_i`, `src_b_id_i`  in  REG_SIZE  source register numbers.
- `rd_a_i`, `rd_b_i`  in  1  the source is actually read.
- `rf_we_i`  in  1  ID instruction writes rd.
- `rf_waddr_i`  in  REG_SIZE  rd.
- `prod_ex_i`, `prod_mem_i`  in  1  result is produced in EX or in MEM (load); exactly one is set when `rf_we_i` is set on the main pipe.
- `flush_i`  in  1  taken branch or jump resolved in EX; kills IF and ID.
- `block_id_o`  out  1  hold IF and ID registers.
- `inject_nops_o`  out  1  bubble into EX/M1.
- `mux_sel_a_o`, `mux_sel_b_o`  out  bypass_id_sel_e  operand source.
- `stall_cnt_o`  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Scoreboard slots, each holding valid, waddr, and a late flag (load):
  - main pipe: EX, MEM, WB;
  - M pipe: M1..M5.
- A slot is valid only when the instruction it tracks writes a register other than x0.
- Age rank by cycles since issue (single issue, so at most one occupant per rank): EX/M1 = 1, MEM/M2 = 2, WB/M3 = 3, M4 = 4, M5 = 5.
- Per source s, when rd_s is set and src ≠ 0, search ranks 1→5; the first matching slot decides:
  - EX match, not late → `EXECUTE_BYPASS`.
  - EX match, late → stall.
  - M1–M4 match → stall.
  - MEM → `MEMORY_BYPASS`.
  - WB → `WRITEBACK_BYPASS`.
  - M5 → `M5_BYPASS`.
  - No match → `ID_RF`.
  - When rd_s is clear or src = 0, the select is `ID_RF`.
- WAW stall: a main-pipe instruction with `rf_we_i` whose rd matches a valid M1–M4 slot.
- Write-port stall: a main-pipe instruction with `rf_we_i` while M2 is valid; otherwise its WB would coincide with M5.
- stall = `valid_id_i` & !`flush_i` & (RAW | WAW | port).
- Outputs:
  - `block_id_o` = stall.
  - `inject_nops_o` = stall | `flush_i`.
- Flush has priority over stall. The ID instruction is discarded and is not inserted into the scoreboard. Slots already in EX and beyond are kept, so a JAL/JALR rd still writes back.
- Scoreboard update every cycle; downstream stages never stall:
  - Main pipe: WB ← MEM ← EX. EX ← the ID instruction when `valid_id_i` & !`is_m_ext_i` & !stall & !`flush_i`; otherwise EX ← invalid.
  - M pipe: M5 ← M4 … M2 ← M1. M1 ← the ID instruction under the same condition with `is_m_ext_i` set; otherwise M1 ← invalid.
  - The late flag is `prod_mem_i` for main-pipe entries and 0 for M-pipe entries.
- `stall_cnt_o` increments on each cycle with stall = 1 and saturates at all-ones.

## Timing
- Reset: all slots invalid; `stall_cnt_o` = 0; hence `block_id_o` = 0, `inject_nops_o` = 0, both selects = `ID_RF`.
- Reset asserted mid-stall clears all state in the same edge, regardless of other inputs.
- Outputs are combinational from the slot state and the ID inputs, valid in the same cycle. No registered output path.
- Load-use costs 1 stall cycle: the consumer sees `MEMORY_BYPASS` the next cycle.
- M-ext result to a dependent instruction: the instruction issued the cycle after the M-ext instruction stalls 4 cycles, then takes `M5_BYPASS`.
- Simultaneous `flush_i` and stall: `block_id_o` = 0, `inject_nops_o` = 1, counter not incremented.

## Structure
- segre_pkg gains:
  - typedef `sb_slot_t` (valid, waddr, late);
  - constant `M_STAGES` = 5.
- Reuses the existing `bypass_id_sel_e` from segre_pkg.
- One sub-module, `segre_bypass_pick`: a combinational priority search for one source, instantiated twice, returning the select and a raw-stall bit.

## Test plan
- `addi x1` then `add x2,x1,x1` back-to-back → second instruction: both selects `EXECUTE_BYPASS`, no stall.
- `lw x5` then `add x6,x5,x0` → 1 cycle `block_id_o` = 1 with `inject_nops_o` = 1; next cycle `mux_sel_a_o` = `MEMORY_BYPASS`; `stall_cnt_o` = 1.
- `mul x7` then `add x8,x7,x7` → 4 stall cycles, then both selects `M5_BYPASS`; `stall_cnt_o` = 4.
- `mul x3`, a non-writing instruction, then `addi x9` → `addi` stalls exactly 1 cycle (write-port rule); `addi x3` in the same position stalls on WAW until the `mul` reaches M5.
- `flush_i` asserted during a load-use stall → `block_id_o` = 0, `inject_nops_o` = 1, the ID instruction is not tracked, and a later reader of its rd gets `ID_RF`.
- `rst_i` pulsed while M2 and EX slots are valid → next cycle all selects `ID_RF`, no stall, counter 0; a read of x0 never stalls or bypasses.

Source files
------------

// File: rtl/segre_pkg.sv
// segre_pkg: shared types for the Segre core ID-stage hazard and bypass logic
package segre_pkg;

    localparam int REG_SIZE = 5;
    localparam int M_STAGES = 5;

    typedef enum logic [2:0] {
        ID_RF,
        EXECUTE_BYPASS,
        MEMORY_BYPASS,
        WRITEBACK_BYPASS,
        M5_BYPASS
    } bypass_id_sel_e;

    typedef struct packed {
        logic                valid;
        logic [REG_SIZE-1:0] waddr;
        logic                late;
    } sb_slot_t;

    function automatic logic slot_hit(input sb_slot_t s, input logic [REG_SIZE-1:0] r);
        return s.valid && s.waddr == r;
    endfunction

endpackage

// File: rtl/segre_bypass_pick.sv
// segre_bypass_pick: youngest-producer search for one ID source operand
module segre_bypass_pick
    import segre_pkg::*;
#(
    parameter int NUM_M_STAGES = M_STAGES
) (
    input  logic                rd_i,
    input  logic [REG_SIZE-1:0] src_i,
    input  sb_slot_t            ex_i,
    input  sb_slot_t            mem_i,
    input  sb_slot_t            wb_i,
    input  sb_slot_t            m_i [NUM_M_STAGES],
    output bypass_id_sel_e      sel_o,
    output logic                raw_o
);

    // Oldest rank first so the youngest matching producer overrides
    always_comb begin
        sel_o = ID_RF;
        raw_o = 1'b0;
        if (rd_i && src_i != '0) begin
            for (int r = NUM_M_STAGES; r >= 1; r--) begin
                if (slot_hit(m_i[r-1], src_i)) begin
                    sel_o = r == NUM_M_STAGES ? M5_BYPASS : ID_RF;
                    raw_o = r != NUM_M_STAGES;
                end
                if (r == 3 && slot_hit(wb_i, src_i)) begin
                    sel_o = WRITEBACK_BYPASS;
                    raw_o = 1'b0;
                end
                if (r == 2 && slot_hit(mem_i, src_i)) begin
                    sel_o = MEMORY_BYPASS;
                    raw_o = 1'b0;
                end
                if (r == 1 && slot_hit(ex_i, src_i)) begin
                    sel_o = ex_i.late ? ID_RF : EXECUTE_BYPASS;
                    raw_o = ex_i.late;
                end
            end
        end
    end

endmodule

// File: rtl/segre_hazard_ctrl.sv
// segre_hazard_ctrl: ID-stage scoreboard driving operand bypass, hold and bubble
module segre_hazard_ctrl
    import segre_pkg::*;
#(
    parameter int NUM_M_STAGES = M_STAGES,
    parameter int CNT_W        = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_id_i,
    input  logic                is_m_ext_i,
    input  logic [REG_SIZE-1:0] src_a_id_i,
    input  logic [REG_SIZE-1:0] src_b_id_i,
    input  logic                rd_a_i,
    input  logic                rd_b_i,
    input  logic                rf_we_i,
    input  logic [REG_SIZE-1:0] rf_waddr_i,
    input  logic                prod_ex_i,
    input  logic                prod_mem_i,
    input  logic                flush_i,
    output logic                block_id_o,
    output logic                inject_nops_o,
    output bypass_id_sel_e      mux_sel_a_o,
    output bypass_id_sel_e      mux_sel_b_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    sb_slot_t ex_q, mem_q, wb_q;
    sb_slot_t m_q [NUM_M_STAGES];
    sb_slot_t id_slot;
    logic     raw_a, raw_b, waw, main_we, stall, issue;

    segre_bypass_pick #(.NUM_M_STAGES(NUM_M_STAGES)) u_pick_a (
        .rd_i(rd_a_i), .src_i(src_a_id_i), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .m_i(m_q), .sel_o(mux_sel_a_o), .raw_o(raw_a)
    );

    segre_bypass_pick #(.NUM_M_STAGES(NUM_M_STAGES)) u_pick_b (
        .rd_i(rd_b_i), .src_i(src_b_id_i), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .m_i(m_q), .sel_o(mux_sel_b_o), .raw_o(raw_b)
    );

    always_comb begin
        waw = 1'b0;
        for (int i = 0; i < NUM_M_STAGES - 1; i++)
            waw = waw | slot_hit(m_q[i], rf_waddr_i);
    end

    // A main-pipe write behind an M2 occupant would share the RF port with M5
    assign main_we       = rf_we_i && !is_m_ext_i;
    assign stall         = valid_id_i && !flush_i && (raw_a || raw_b || (main_we && (waw || m_q[1].valid)));
    assign issue         = valid_id_i && !flush_i && !stall;
    assign block_id_o    = stall;
    assign inject_nops_o = stall || flush_i;
    assign id_slot       = '{valid: rf_we_i && rf_waddr_i != '0, waddr: rf_waddr_i,
                             late: prod_mem_i && !prod_ex_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_o <= '0;
            for (int i = 0; i < NUM_M_STAGES; i++) m_q[i] <= '0;
        end else begin
            ex_q  <= (issue && !is_m_ext_i) ? id_slot : '0;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            m_q[0] <= (issue && is_m_ext_i) ? '{valid: id_slot.valid, waddr: id_slot.waddr, late: 1'b0} : '0;
            for (int i = 1; i < NUM_M_STAGES; i++) m_q[i] <= m_q[i-1];
            if (stall && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// tb_segre_hazard_ctrl: directed plus random check against an issue-history model
module tb_segre_hazard_ctrl;
    import segre_pkg::*;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic valid, is_m, rd_a, rd_b, we, p_ex, p_mem, flush;
    logic [4:0] src_a, src_b, waddr;
    logic block, inj;
    bypass_id_sel_e sel_a, sel_b;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    segre_hazard_ctrl #(.NUM_M_STAGES(5), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .valid_id_i(valid), .is_m_ext_i(is_m),
        .src_a_id_i(src_a), .src_b_id_i(src_b), .rd_a_i(rd_a), .rd_b_i(rd_b),
        .rf_we_i(we), .rf_waddr_i(waddr), .prod_ex_i(p_ex), .prod_mem_i(p_mem),
        .flush_i(flush), .block_id_o(block), .inject_nops_o(inj),
        .mux_sel_a_o(sel_a), .mux_sel_b_o(sel_b), .stall_cnt_o(cnt)
    );

    // hist[k] is the instruction that left ID k cycles ago
    typedef struct packed { logic v; logic m; logic we; logic [4:0] rd; logic late; } iss_t;
    iss_t hist [1:5];
    int cnt_m = 0;
    int total = 0, bad = 0;
    bit armed = 0;

    function automatic void src_model(input logic r, input logic [4:0] s,
                                      output bypass_id_sel_e sel, output bit st);
        sel = ID_RF;
        st = 0;
        if (!r || s == 0) return;
        for (int k = 1; k <= 5; k++) begin
            if (hist[k].v && hist[k].we && hist[k].rd == s && (hist[k].m || k <= 3)) begin
                if (hist[k].m) begin
                    if (k == 5) sel = M5_BYPASS; else st = 1;
                end else if (k == 1) begin
                    if (hist[k].late) st = 1; else sel = EXECUTE_BYPASS;
                end else sel = (k == 2) ? MEMORY_BYPASS : WRITEBACK_BYPASS;
                return;
            end
        end
    endfunction

    function automatic bit model_stall();
        bypass_id_sel_e sa, sb;
        bit ra, rb, waw, port;
        src_model(rd_a, src_a, sa, ra);
        src_model(rd_b, src_b, sb, rb);
        waw = 0;
        for (int k = 1; k <= 4; k++)
            if (hist[k].v && hist[k].m && hist[k].we && hist[k].rd != 0 && hist[k].rd == waddr) waw = 1;
        port = hist[2].v && hist[2].m && hist[2].we && hist[2].rd != 0;
        return valid && !flush && (ra || rb || (we && !is_m && (waw || port)));
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit st;
        if (rst) begin
            for (int k = 1; k <= 5; k++) hist[k] = '0;
            cnt_m = 0;
        end else begin
            st = model_stall();
            if (st && cnt_m < CMAX) cnt_m++;
            for (int k = 5; k >= 2; k--) hist[k] = hist[k-1];
            hist[1] = (valid && !flush && !st) ? '{v: 1'b1, m: is_m, we: we, rd: waddr, late: p_mem && !is_m} : '0;
        end
    end

    always @(negedge clk) begin
        bypass_id_sel_e ea, eb;
        bit ra, rb, st;
        if (armed && !rst) begin
            src_model(rd_a, src_a, ea, ra);
            src_model(rd_b, src_b, eb, rb);
            st = model_stall();
            chk("block", int'(block), int'(st));
            chk("inject", int'(inj), int'(st || flush));
            chk("sel_a", int'(sel_a), int'(ea));
            chk("sel_b", int'(sel_b), int'(eb));
            chk("cnt", int'(cnt), cnt_m);
        end
    end

    task automatic drv(input bit v, input bit m, input logic [4:0] a, input bit ra,
                       input logic [4:0] b, input bit rb, input bit w, input logic [4:0] rd,
                       input bit late, input bit fl);
        valid = v; is_m = m; src_a = a; rd_a = ra; src_b = b; rd_b = rb;
        we = w; waddr = rd; p_mem = w && !m && late; p_ex = w && !m && !late; flush = fl;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(n);
    endtask

    task automatic lit(input string n, input int blk, input int nop, input int sa, input int sb, input int c);
        @(negedge clk);
        chk({n, "_blk"}, int'(block), blk);
        chk({n, "_inj"}, int'(inj), nop);
        chk({n, "_sa"}, int'(sel_a), sa);
        chk({n, "_sb"}, int'(sel_b), sb);
        chk({n, "_cnt"}, int'(cnt), c);
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        step(2);
        rst = 0;
        armed = 1;
        lit("reset", 0, 0, ID_RF, ID_RF, 0);
        // addi x1 ; add x2,x1,x1
        drv(1, 0, 0, 1, 0, 0, 1, 1, 0, 0); step();
        drv(1, 0, 1, 1, 1, 1, 1, 2, 0, 0);
        lit("ex_byp", 0, 0, EXECUTE_BYPASS, EXECUTE_BYPASS, 0);
        step(); idle(6);
        // lw x5 ; add x6,x5,x0
        drv(1, 0, 0, 1, 0, 0, 1, 5, 1, 0); step();
        drv(1, 0, 5, 1, 0, 1, 1, 6, 0, 0);
        lit("ld_use", 1, 1, ID_RF, ID_RF, 0);
        step();
        lit("ld_mem", 0, 0, MEMORY_BYPASS, ID_RF, 1);
        step(); idle(6);
        // mul x7 ; add x8,x7,x7
        drv(1, 1, 0, 1, 0, 1, 1, 7, 0, 0); step();
        drv(1, 0, 7, 1, 7, 1, 1, 8, 0, 0);
        for (int i = 0; i < 4; i++) begin
            lit("m_stall", 1, 1, ID_RF, ID_RF, 1 + i);
            step();
        end
        lit("m5_byp", 0, 0, M5_BYPASS, M5_BYPASS, 5);
        step(); idle(6);
        // mul x3 ; non-writing ; addi x9 -> write-port stall
        drv(1, 1, 0, 1, 0, 1, 1, 3, 0, 0); step();
        drv(1, 0, 0, 1, 0, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 1, 0, 0, 1, 9, 0, 0);
        lit("port", 1, 1, ID_RF, ID_RF, 5);
        step();
        lit("port_go", 0, 0, ID_RF, ID_RF, 6);
        step(); idle(6);
        // mul x3 ; non-writing ; addi x3 -> WAW until M5
        drv(1, 1, 0, 1, 0, 1, 1, 3, 0, 0); step();
        drv(1, 0, 0, 1, 0, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 1, 0, 0, 1, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            lit("waw", 1, 1, ID_RF, ID_RF, 6 + i);
            step();
        end
        lit("waw_go", 0, 0, ID_RF, ID_RF, 9);
        step(); idle(6);
        // flush during load-use stall
        drv(1, 0, 0, 1, 0, 0, 1, 5, 1, 0); step();
        drv(1, 0, 5, 1, 0, 1, 1, 6, 0, 1);
        lit("flush", 0, 1, ID_RF, ID_RF, 9);
        step();
        drv(1, 0, 6, 1, 6, 1, 1, 10, 0, 0);
        lit("flushed_rd", 0, 0, ID_RF, ID_RF, 9);
        step(); idle(6);
        // reset with M2 and EX occupied
        drv(1, 1, 0, 1, 0, 1, 1, 11, 0, 0); step();
        drv(1, 0, 0, 1, 0, 1, 1, 12, 0, 0); step();
        drv(1, 0, 11, 1, 12, 1, 1, 13, 0, 0);
        rst = 1; step(); rst = 0;
        lit("post_rst", 0, 0, ID_RF, ID_RF, 0);
        step();
        drv(1, 0, 0, 1, 0, 0, 1, 0, 1, 0); step();
        drv(1, 0, 0, 1, 0, 1, 1, 14, 0, 0);
        lit("x0", 0, 0, ID_RF, ID_RF, 0);
        step();
        // random traffic on a small register set, exercising counter saturation
        for (int i = 0; i < 3000; i++) begin
            bit m;
            m = ($urandom_range(0, 99) < 30);
            drv($urandom_range(0, 99) < 85, m, 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 70,
                5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 999) < 5);
            step();
        end
        rst = 0;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
